// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: drives datapath selects/strobes, counts retirements, halts on faults.
// Latency (mem_ready tied 1): BRANCH/JAL/JALR 3 cycles, R/I-ALU/STORE 4 cycles, LOAD 5 cycles.
// Backpressure: mem_ready low stalls FETCH/MEM; WAIT_LIMIT consecutive stalls halt with bus_error.
module multicycle_control_fsm #(
   parameter int INSTRET_WIDTH = 32,
   parameter int WAIT_LIMIT    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [6:0]               opcode,
   input  logic                     mem_ready,
   input  logic                     branch_taken,
   output logic                     pc_write,
   output logic                     ir_write,
   output logic                     iord,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [1:0]               mem_to_reg,
   output logic                     reg_write,
   output logic [1:0]               alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic [1:0]               alu_op,
   output logic [1:0]               pc_source,
   output logic                     illegal,
   output logic                     bus_error,
   output logic [2:0]               state,
   output logic [INSTRET_WIDTH-1:0] instret
);

   // Wait counter only needs to reach WAIT_LIMIT-1; the limit itself is detected combinationally.
   localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Datapath select encodings
   localparam logic [1:0] SRC_A_PC     = 2'd0;
   localparam logic [1:0] SRC_A_RS1    = 2'd1;
   localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
   localparam logic [1:0] SRC_B_RS2    = 2'd0;
   localparam logic [1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] ALU_ADD      = 2'b00;
   localparam logic [1:0] ALU_BRANCH   = 2'b01;
   localparam logic [1:0] ALU_FUNCT    = 2'b10;
   localparam logic [1:0] PC_SRC_ALU   = 2'd0;
   localparam logic [1:0] PC_SRC_OUT   = 2'd1;
   localparam logic [1:0] PC_SRC_JALR  = 2'd2;
   localparam logic [1:0] WB_ALUOUT    = 2'd0;
   localparam logic [1:0] WB_MDR       = 2'd1;
   localparam logic [1:0] WB_PC        = 2'd2;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [6:0]               opcode_q;
   logic [WAIT_W-1:0]        wait_q;
   logic [INSTRET_WIDTH-1:0] instret_q;
   logic                     illegal_q;
   logic                     bus_error_q;

   logic                     retire;
   logic                     set_illegal;
   logic                     mem_wait;
   logic                     timeout;

   function automatic logic is_supported(input logic [6:0] op);
      case (op)
         OP_R, OP_I_ALU, OP_LOAD, OP_STORE,
         OP_BRANCH, OP_JAL, OP_JALR: is_supported = 1'b1;
         default:                    is_supported = 1'b0;
      endcase
   endfunction

   // A memory-facing state waiting on mem_ready; timeout fires on the cycle the count would hit the limit
   // and mem_ready is still low, so a late ready always wins.
   assign mem_wait = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
   assign timeout  = (WAIT_LIMIT != 0) && mem_wait && (wait_q == WAIT_LAST);

   // Next-state selection and per-state datapath control
   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = WB_ALUOUT;
      reg_write   = 1'b0;
      alu_src_a   = SRC_A_PC;
      alu_src_b   = SRC_B_RS2;
      alu_op      = ALU_ADD;
      pc_source   = PC_SRC_ALU;
      retire      = 1'b0;
      set_illegal = 1'b0;

      case (state_q)
         FETCH: begin
            // PC + 4 is computed alongside the read so PC and IR load on the same edge.
            iord      = 1'b0;
            mem_read  = 1'b1;
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_FOUR;
            alu_op    = ALU_ADD;
            pc_source = PC_SRC_ALU;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)    state_d = DECODE;
            else if (timeout) state_d = HALT;
         end
         DECODE: begin
            // Speculatively form old PC + imm into ALUOut for branch/JAL targets.
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_ADD;
            if (is_supported(opcode)) begin
               state_d = EXEC;
            end else begin
               state_d     = HALT;
               set_illegal = 1'b1;
            end
         end
         EXEC: begin
            case (opcode_q)
               OP_R: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = SRC_B_RS2;
                  alu_op    = ALU_FUNCT;
                  state_d   = WB;
               end
               OP_I_ALU: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = SRC_B_IMM;
                  alu_op    = ALU_FUNCT;
                  state_d   = WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = SRC_B_IMM;
                  alu_op    = ALU_ADD;
                  state_d   = MEM;
               end
               OP_BRANCH: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = SRC_B_RS2;
                  alu_op    = ALU_BRANCH;
                  pc_source = PC_SRC_OUT;
                  pc_write  = branch_taken;
                  state_d   = FETCH;
                  retire    = 1'b1;
               end
               OP_JAL: begin
                  // rd takes the current PC, which already holds old PC + 4.
                  pc_source  = PC_SRC_OUT;
                  pc_write   = 1'b1;
                  reg_write  = 1'b1;
                  mem_to_reg = WB_PC;
                  state_d    = FETCH;
                  retire     = 1'b1;
               end
               OP_JALR: begin
                  alu_src_a  = SRC_A_RS1;
                  alu_src_b  = SRC_B_IMM;
                  alu_op     = ALU_ADD;
                  pc_source  = PC_SRC_JALR;
                  pc_write   = 1'b1;
                  reg_write  = 1'b1;
                  mem_to_reg = WB_PC;
                  state_d    = FETCH;
                  retire     = 1'b1;
               end
               default: state_d = FETCH;
            endcase
         end
         MEM: begin
            iord = 1'b1;
            if (opcode_q == OP_STORE) begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  state_d = FETCH;
                  retire  = 1'b1;
               end else if (timeout) begin
                  state_d = HALT;
               end
            end else begin
               mem_read = 1'b1;
               if (mem_ready)    state_d = WB;
               else if (timeout) state_d = HALT;
            end
         end
         WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode_q == OP_LOAD) ? WB_MDR : WB_ALUOUT;
            state_d    = FETCH;
            retire     = 1'b1;
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = FETCH;
      endcase

      // Reset abandons any access in flight: no strobe may reach the datapath.
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         retire    = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Opcode latch, loaded while the IR contents are being decoded
   always_ff @(posedge clk) begin
      if (reset)                  opcode_q <= 7'd0;
      else if (state_q == DECODE) opcode_q <= opcode;
   end

   // Consecutive mem_ready-low cycles within one FETCH/MEM visit
   always_ff @(posedge clk) begin
      if (reset)
         wait_q <= '0;
      else if ((WAIT_LIMIT != 0) && mem_wait && (state_d == state_q))
         wait_q <= wait_q + 1'b1;
      else
         wait_q <= '0;
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (reset)       instret_q <= '0;
      else if (retire) instret_q <= instret_q + 1'b1;
   end

   // Sticky fault flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         if (set_illegal) illegal_q   <= 1'b1;
         if (timeout)     bus_error_q <= 1'b1;
      end
   end

   assign state     = state_q;
   assign instret   = instret_q;
   assign illegal   = illegal_q;
   assign bus_error = bus_error_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control sequencer that lets the RV32I datapath run multi-cycle.
- One memory, one ALU and one adder path are shared across FETCH/DECODE/EXEC/MEM/WB states.
- Drives datapath mux selects and write strobes from the latched opcode, a memory ready handshake and the branch comparator result.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
INSTRET_WIDTH, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_WIDTH)
WAIT_LIMIT, 16, max consecutive cycles waiting on mem_ready before bus error; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  Instruction_Code[6:0] from IR; sampled in DECODE
mem_ready  in  1  memory access complete this cycle (tie 1 for zero-wait memory)
branch_taken  in  1  branch condition from comparator; valid in EXEC
pc_write  out  1  PC register load strobe
ir_write  out  1  IR and old-PC register load strobe
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  2  rd write source: 0 = ALUOut, 1 = MDR, 2 = PC (return address)
reg_write  out  1  register file write strobe
alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old PC
alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
pc_source  out  2  0 = ALU result, 1 = ALUOut (target), 2 = ALU result with bit0 cleared
illegal  out  1  sticky: unsupported opcode decoded
bus_error  out  1  sticky: mem_ready timeout
state  out  3  current state encoding (debug)
instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. Values 6 and 7 go to FETCH.
- Reset:
  - While reset is high, every strobe output (pc_write, ir_write, mem_read, mem_write, reg_write) is forced 0.
  - At the next edge: state = FETCH, instret = 0, illegal = 0, bus_error = 0, wait counter = 0, opcode latch = 0.
  - Reset mid-access abandons the access. No retirement is counted.
- Default outputs: all strobes 0, every select 0, alu_op = 00, unless stated below.
- FETCH:
  - Drives iord = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 1, alu_op = 00, pc_source = 0.
  - ir_write = pc_write = mem_ready.
  - mem_ready = 1 -> DECODE; otherwise stay in FETCH.
- DECODE:
  - Latches opcode internally.
  - Drives alu_src_a = 2, alu_src_b = 2, alu_op = 00 (ALUOut <= branch/JAL target).
  - Supported opcode -> EXEC; any other -> HALT with illegal = 1.
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR.
- EXEC, decoded from the latched opcode:
  - R: alu_src_a = 1, alu_src_b = 0, alu_op = 10 -> WB.
  - I-ALU: alu_src_a = 1, alu_src_b = 2, alu_op = 10 -> WB.
  - LOAD/STORE: alu_src_a = 1, alu_src_b = 2, alu_op = 00 -> MEM.
  - BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 01, pc_source = 1, pc_write = branch_taken -> FETCH; retire.
  - JAL: pc_source = 1, pc_write = 1, reg_write = 1, mem_to_reg = 2 -> FETCH; retire.
  - JALR: alu_src_a = 1, alu_src_b = 2, alu_op = 00, pc_source = 2, pc_write = 1, reg_write = 1, mem_to_reg = 2 -> FETCH; retire.
  - For JAL/JALR, rd receives the PC value before the edge, i.e. old PC + 4.
- MEM: iord = 1.
  - LOAD: mem_read = 1; mem_ready -> WB.
  - STORE: mem_write = 1, held until mem_ready -> FETCH; retire.
- WB: reg_write = 1, mem_to_reg = 1 for LOAD, 0 otherwise -> FETCH; retire.
- Latency with mem_ready tied 1:
  - BRANCH/JAL/JALR: 3 cycles.
  - R/I-ALU/STORE: 4 cycles.
  - LOAD: 5 cycles.
- instret: increments by 1 on the edge of each retire transition; wraps to 0 after all-ones.
- Wait counter:
  - Counts cycles in FETCH or MEM with mem_ready = 0; cleared when mem_ready = 1 or on state change.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT -> HALT, bus_error = 1.
  - mem_ready arriving on the same cycle the limit is reached wins: no error.
- HALT: all strobes 0, state held until reset. illegal and bus_error are sticky.

Test Plan:
- R-type 0110011 with mem_ready = 1 -> state sequence 0,1,2,4,0; reg_write high only in WB; instret 0 -> 1 after 4 cycles.
- LOAD 0000011, mem_ready low for 3 cycles in MEM -> mem_read and iord held at 1 for 4 MEM cycles; WB has mem_to_reg = 1; total 8 cycles.
- BRANCH 1100011:
  - branch_taken = 1 in EXEC -> pc_write = 1, pc_source = 1, back to FETCH after 3 cycles.
  - branch_taken = 0 -> pc_write = 0 in EXEC; instret still increments.
- JALR 1100111 -> single EXEC cycle with pc_write = 1, pc_source = 2, reg_write = 1, mem_to_reg = 2.
- Opcode 0000000 in DECODE -> HALT (state = 5), illegal = 1, no strobes for 20 cycles; reset -> FETCH, illegal = 0.
- WAIT_LIMIT = 4, mem_ready = 0 in FETCH -> bus_error = 1 and state = 5 after 4 wait cycles. Repeat with mem_ready = 1 on the 4th cycle -> no error, DECODE.
